// File: rtl/microwave_pkg.sv
// Shared encodings for the microwave cook-cycle sequencer: FSM states,
// BCD digit limits and the MM:SS time record.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    localparam mmss_t MMSS_ONE_SEC = 16'h0001;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register with keypad shift-in, one-second
// decrement (borrowing through 59-second minutes) and clear.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift,
    input  logic       dec,
    input  logic [3:0] digit,
    output mmss_t      t,
    output logic       is_zero
);

    mmss_t dec_t;

    assign is_zero = (t == '0);

    always_comb begin
        dec_t = t;
        if (t.sec_ones != BCD_ZERO) begin
            dec_t.sec_ones = t.sec_ones - 4'd1;
        end else begin
            dec_t.sec_ones = BCD_NINE;
            if (t.sec_tens != BCD_ZERO) begin
                dec_t.sec_tens = t.sec_tens - 4'd1;
            end else begin
                dec_t.sec_tens = BCD_FIVE;
                if (t.min_ones != BCD_ZERO) begin
                    dec_t.min_ones = t.min_ones - 4'd1;
                end else begin
                    dec_t.min_ones = BCD_NINE;
                    dec_t.min_tens = t.min_tens - 4'd1;
                end
            end
        end
    end

    // Decrement is blocked at 00:00 so min_tens can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (clr) begin
            t <= '0;
        end else if (dec && !is_zero) begin
            t <= dec_t;
        end else if (shift) begin
            t.min_tens <= t.min_ones;
            t.min_ones <= t.sec_tens;
            t.sec_tens <= t.sec_ones;
            t.sec_ones <= digit;
        end
    end

endmodule

// File: rtl/microwave_sequencer.sv
// Cook-cycle sequencer: keypad entry, 1 Hz countdown, door/stop pause,
// and a timed end-of-cycle beep. All outputs are registered.
module microwave_sequencer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic       timer_done,
    output logic       beep,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    state_t          st, nxt;
    logic            startn_q, stopn_q;
    logic            start_edge, stop_edge;
    logic [PW-1:0]   presc;
    logic [BW-1:0]   beep_cnt;
    logic            timed, tick;
    logic            t_clr, t_dec, t_shift;
    logic            key_ok, will_zero, is_zero;
    mmss_t           t;

    assign start_edge = startn_q & ~startn;
    assign stop_edge  = stopn_q & ~stopn;
    assign timed      = (st == ST_COOK) || (st == ST_DONE);
    assign tick       = timed && (presc == PW'(TICKS_PER_SEC - 1));
    // A digit > 5 in sec_ones would become an illegal tens-of-seconds value.
    assign key_ok     = key_valid && (key_digit <= BCD_NINE) && (t.sec_ones <= BCD_FIVE);
    assign will_zero  = (t == MMSS_ONE_SEC);

    bcd_mmss_counter u_time (
        .clk     (clk),
        .rst     (rst),
        .clr     (t_clr),
        .shift   (t_shift),
        .dec     (t_dec),
        .digit   (key_digit),
        .t       (t),
        .is_zero (is_zero)
    );

    always_comb begin
        nxt     = st;
        t_clr   = 1'b0;
        t_dec   = 1'b0;
        t_shift = 1'b0;
        if (clear) begin
            nxt   = ST_IDLE;
            t_clr = 1'b1;
        end else begin
            case (st)
                ST_IDLE, ST_SET: begin
                    if (start_edge && door_closed && stopn && !is_zero) begin
                        nxt = ST_COOK;
                    end else if (key_ok) begin
                        nxt     = ST_SET;
                        t_shift = 1'b1;
                    end
                end
                ST_COOK: begin
                    if (!door_closed || stop_edge) begin
                        nxt = ST_PAUSE;
                    end else if (tick) begin
                        t_dec = 1'b1;
                        if (will_zero) nxt = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (stop_edge) begin
                        nxt   = ST_IDLE;
                        t_clr = 1'b1;
                    end else if (start_edge && door_closed && stopn) begin
                        nxt = ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (!door_closed || stop_edge) begin
                        nxt = ST_IDLE;
                    end else if (tick && (beep_cnt == BW'(BEEP_SECS - 1))) begin
                        nxt = ST_IDLE;
                    end
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // Entering COOK or DONE restarts the partial second, so a resume
    // always gets a full second before the next decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            presc      <= '0;
            beep_cnt   <= '0;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
            beep       <= 1'b0;
        end else begin
            st       <= nxt;
            startn_q <= startn;
            stopn_q  <= stopn;
            if (((nxt == ST_COOK) || (nxt == ST_DONE)) && (nxt != st))
                presc <= '0;
            else if (timed)
                presc <= tick ? '0 : presc + PW'(1);
            else
                presc <= '0;
            if ((nxt == ST_DONE) && (st != ST_DONE))
                beep_cnt <= '0;
            else if ((st == ST_DONE) && tick)
                beep_cnt <= beep_cnt + BW'(1);
            mag_on     <= (nxt == ST_COOK);
            timer_done <= (nxt == ST_DONE);
            beep       <= (nxt == ST_DONE);
        end
    end

    assign state    = st;
    assign min_tens = t.min_tens;
    assign min_ones = t.min_ones;
    assign sec_tens = t.sec_tens;
    assign sec_ones = t.sec_ones;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer with TICKS_PER_SEC=4, BEEP_SECS=3;
// expected values are hand-computed per step.
module tb_microwave_sequencer;

    logic       clk = 1'b0;
    logic       rst, startn, stopn, clear, door_closed, key_valid;
    logic [3:0] key_digit;
    logic       mag_on, timer_done, beep;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic [15:0] tm;
    int errors = 0;
    int checks = 0;

    assign tm = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    microwave_sequencer #(.TICKS_PER_SEC(4), .BEEP_SECS(3)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clear(clear),
        .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
        .mag_on(mag_on), .timer_done(timer_done), .beep(beep),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .state(state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic start_btn();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; startn = 1'b1; stopn = 1'b1; clear = 1'b0;
        door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        #1;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_time", tm, 16'h0000);
        chk("rst_outs", 16'({mag_on, timer_done, beep}), 16'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // keypad entry and rejection
        press(4'd1); press(4'd3); press(4'd0);
        chk("key_0130", tm, 16'h0130);
        chk("key_state_set", 16'(state), 16'd1);
        press(4'd7);
        chk("key_1307", tm, 16'h1307);
        press(4'd2);
        chk("key_reject_gt5", tm, 16'h1307);
        do_clear();
        press(4'd12);
        chk("key_non_bcd", tm, 16'h0000);
        chk("key_non_bcd_state", 16'(state), 16'd0);

        // full cycle 00:02
        press(4'd2);
        start_btn();
        chk("cook_mag_on", 16'(mag_on), 16'd1);
        chk("cook_state", 16'(state), 16'd2);
        step(3);
        chk("cook_pre_tick", tm, 16'h0002);
        step(1);
        chk("cook_0001", tm, 16'h0001);
        step(3);
        chk("cook_still_0001", tm, 16'h0001);
        step(1);
        chk("done_state", 16'(state), 16'd4);
        chk("done_outs", 16'({mag_on, timer_done, beep}), 16'b011);
        chk("done_time", tm, 16'h0000);
        step(11);
        chk("done_held", 16'({state, timer_done, beep}), {11'd0, 3'd4, 2'b11});
        step(1);
        chk("done_to_idle", 16'({state, mag_on, timer_done, beep}), 16'd0);

        // borrow chains
        press(4'd1); press(4'd0); press(4'd0);
        start_btn();
        step(4);
        chk("borrow_0059", tm, 16'h0059);
        do_clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        start_btn();
        step(4);
        chk("borrow_0959", tm, 16'h0959);
        do_clear();
        chk("clear_cook", 16'({state, mag_on}), 16'd0);

        // door open pause and resume
        press(4'd5);
        start_btn();
        step(2);
        door_closed = 1'b0;
        step(1);
        chk("pause_state", 16'(state), 16'd3);
        chk("pause_mag_off", 16'(mag_on), 16'd0);
        step(5);
        chk("pause_hold", tm, 16'h0005);
        door_closed = 1'b1;
        start_btn();
        chk("resume_mag_on", 16'({state, mag_on}), {12'd0, 3'd2, 1'b1});
        step(3);
        chk("resume_full_sec", tm, 16'h0005);
        step(1);
        chk("resume_0004", tm, 16'h0004);
        step(3);
        door_closed = 1'b0;
        step(1);
        chk("tick_door_pause", 16'(state), 16'd3);
        chk("tick_door_nodec", tm, 16'h0004);
        door_closed = 1'b1;

        // stop in pause
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        chk("pause_stop_idle", 16'(state), 16'd0);
        chk("pause_stop_time", tm, 16'h0000);
        step(1);

        // clear coinciding with a tick
        press(4'd5);
        start_btn();
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_tick_state", 16'({state, mag_on}), 16'd0);
        chk("clear_tick_time", tm, 16'h0000);

        // ignored starts
        start_btn();
        chk("start_zero", 16'({state, mag_on}), 16'd0);
        step(1);
        press(4'd3);
        door_closed = 1'b0;
        start_btn();
        chk("start_door_open", 16'({state, mag_on}), {12'd0, 3'd1, 1'b0});
        door_closed = 1'b1;
        step(1);

        // async reset mid-cook
        start_btn();
        chk("cook_before_rst", 16'(mag_on), 16'd1);
        step(2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 16'({state, mag_on, timer_done, beep}), 16'd0);
        chk("async_rst_time", tm, 16'h0000);
        step(1);
        rst = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microwave_sequencer.md
# microwave_sequencer

Clocked cook-cycle sequencer for the microwave oven controller. It takes keypad time entry as MM:SS BCD, counts the cook time down at 1 Hz and drives the magnetron enable. It pauses on door-open or stop, and signals completion with timer_done and a timed beep. It replaces the free-running set/reset latch control with a registered state machine; all front-panel inputs arrive debounced and synchronous to clk.

## Interface
- TICKS_PER_SEC, default 50_000_000: clk cycles per cook second; the bench uses 4.
- BEEP_SECS, default 3: length of the end-of-cycle beep, in seconds.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset (already decided).
- startn  in  1  start button, active-low level; only its falling edge acts.
- stopn  in  1  stop button, active-low level; only its falling edge acts.
- clear  in  1  active-high clear; level-sensitive, acts every cycle it is high.
- door_closed  in  1  1 = door closed.
- key_valid  in  1  one-cycle strobe for a keypad digit.
- key_digit  in  4  BCD digit 0–9; values 10–15 are ignored.
- mag_on  out  1  magnetron enable, registered.
- timer_done  out  1  high while in DONE.
- beep  out  1  high while in DONE.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  remaining time in BCD.
- state  out  3  current FSM state, for debug.

## Operation
- States: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
- Reset: state IDLE, all digits 0, mag_on/timer_done/beep 0, prescaler 0, start/stop edge registers 1.
- start_edge = startn_q & ~startn; stop_edge = stopn_q & ~stopn.
- Priority when events coincide in one cycle: clear > (door open | stop_edge) > tick > start_edge > key.

Key entry (IDLE and SET only):
- A valid digit shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit. State goes to SET.
- The key is rejected if the current sec_ones > 5, because it would land in sec_tens as an invalid value.
- A digit shifted out of min_tens is discarded.

Transitions:
- IDLE/SET: start_edge with door_closed, stopn=1 and time ≠ 00:00 → COOK. A start with zero time is ignored.
- Any state: clear → IDLE with time zeroed.
- COOK: door_closed=0 or stop_edge → PAUSE, time kept. Tick → decrement; if the result is 00:00 → DONE.
- PAUSE: start_edge with door_closed and stopn=1 → COOK. stop_edge → IDLE with time zeroed.
- DONE: after BEEP_SECS ticks → IDLE. stop_edge or door open → IDLE immediately.

BCD decrement:
- sec_ones 0→9 borrows from sec_tens; sec_tens 0→5 borrows from min_ones; min_ones 0→9 borrows from min_tens.
- Maximum time 99:59. A decrement never occurs at 00:00.

Prescaler:
- Counts 0..TICKS_PER_SEC−1 only in COOK and DONE. tick = (count == TICKS_PER_SEC−1).
- Cleared on every entry to COOK or DONE, so a resume restarts the partial second.
- A beep counter counts ticks in DONE.

Outputs:
- mag_on = (state == COOK), registered from the next state.
- timer_done = beep = (state == DONE), both registered.

## Timing
- All outputs update on the clk edge that changes state; no combinational input→output paths.
- Start: the start_edge seen at edge N gives mag_on=1 after edge N.
- First decrement happens TICKS_PER_SEC cycles after COOK entry. Time T seconds reaches 00:00 and enters DONE T·TICKS_PER_SEC cycles after entry.
- Door open at edge N gives mag_on=0 after edge N, a one-cycle worst case.
- Tick and door-open in the same cycle → PAUSE, with no decrement.
- DONE lasts BEEP_SECS·TICKS_PER_SEC cycles.
- rst asserted mid-COOK drops mag_on asynchronously.

## Structure
- microwave_pkg holds the state encodings (IDLE..DONE) and the BCD constants (9, 5, 0).
- Sub-module bcd_mmss_counter: four BCD digit registers with shift-load, decrement and clear inputs, plus an is_zero output.
- microwave_sequencer holds the FSM, edge detectors, prescaler and beep counter.

## Test plan
- Keys 1,3,0 → 01:30, state SET. Key 7 then key 2 → 13:07 → 30:72 is rejected because sec_ones 7>5; time stays 13:07.
- 00:02 + start (TICKS_PER_SEC=4) → mag_on after 1 cycle; 00:01 at +4 cycles; DONE at +8 with mag_on=0 and timer_done=beep=1 for 12 cycles; then IDLE.
- 01:00 cooking, one tick → 00:59; 10:00 → 09:59 (borrow chain).
- COOK at 00:05, door opens → PAUSE, mag_on=0 next cycle, time 00:05 held. Door closes + start → COOK, prescaler restarts at 0.
- PAUSE + stop_edge → IDLE, 00:00. COOK + clear together with a tick → IDLE, 00:00, no decrement.
- Start with time 00:00 or door open → stays IDLE/SET, mag_on 0. rst asserted mid-COOK → all outputs 0 immediately.
